// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive deframer.
//   state_t        : parser state encoding (also exported on the debug port)
//   SYNC_BYTE_DEF  : default frame start marker
//   CHK_W          : checksum width (8-bit wrapping sum)
//   idx_w()        : address width for a buffer of max_len entries (min 1)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CHK_W         = 8;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  // A one-entry buffer still needs a one-bit address.
  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
// Payload byte RAM: synchronous write, asynchronous (combinational) read.
// Contents are not reset; the parser never reads an entry it has not written
// for the current frame.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data (combinational from rd_addr_i)
// -----------------------------------------------------------------------------
module uart_frame_buf #(
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// Parses frames of the form SYNC, LEN, LEN payload bytes, CHK from the byte
// strobes of a UART receiver. The payload is buffered and only released on
// the output stream after the checksum (LEN + payload, 8-bit wrapping) has
// matched. Bad, oversized (or, optionally, stalled) frames are dropped and
// flagged with frameErr.
//
// Optional feature: define UART_DEFRAMER_TIMEOUT_EN to abort a partial frame
// after TIMEOUT_CLKS idle cycles in LEN/PAYLOAD/CHK. Without it a partial
// frame waits indefinitely.
//
// Stream handshake: outValid/outByte/outLast hold steady until the cycle in
// which outValid & outReady are both high; that cycle transfers one byte.
//
// Ports:
//   iclk, irst   : clock, asynchronous active-high reset
//   rxDataValid  : one-cycle strobe, rxByte valid (no backpressure)
//   rxByte       : received byte
//   outValid     : payload byte available
//   outReady     : consumer ready
//   outByte      : payload byte (0 when outValid=0)
//   outLast      : final payload byte of the frame
//   frameOk      : one-cycle pulse, good frame accepted
//   frameErr     : one-cycle pulse, checksum/length/timeout error
//   rxOverrun    : one-cycle pulse, byte dropped while draining
//   dbgState     : current parser state (debug)
// -----------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       rxDataValid,
  input  logic [7:0] rxByte,
  output logic       outValid,
  input  logic       outReady,
  output logic [7:0] outByte,
  output logic       outLast,
  output logic       frameOk,
  output logic       frameErr,
  output logic       rxOverrun,
  output state_t     dbgState
);

  localparam int                AW        = idx_w(MAX_LEN);
  // One extra index bit so a full buffer's count is representable.
  localparam int                IW        = AW + 1;
  localparam logic [IW-1:0]     IDX_ONE   = 1;
  localparam logic [8:0]        MAX_LEN_9 = 9'(MAX_LEN);

  state_t           state_q,  state_d;
  logic [7:0]       len_q,    len_d;
  logic [CHK_W-1:0] sum_q,    sum_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic             ok_q,     ok_d;
  logic             err_q,    err_d;
  logic             ovr_q,    ovr_d;

  logic             wr_en;
  logic [7:0]       rd_data;
  logic             wr_last;
  logic             rd_last;
  logic             tmo_hit;

  // Index compares done in 9 bits so len=255 and full-buffer counts never wrap.
  assign wr_last = ((9'(wr_idx_q) + 9'd1) == {1'b0, len_q});
  assign rd_last = ((9'(rd_idx_q) + 9'd1) == {1'b0, len_q});

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef UART_DEFRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_frame;

  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);

  // Counter restarts on every strobe and idles at zero outside a frame, so a
  // fresh frame always starts with a full timeout window.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (in_frame && !rxDataValid) begin
      if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CLKS;
  assign tmo_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Payload buffer
  // ---------------------------------------------------------------------------
  uart_frame_buf #(
    .AW(AW)
  ) u_buf (
    .clk_i    (iclk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_idx_q[AW-1:0]),
    .wr_data_i(rxByte),
    .rd_addr_i(rd_idx_q[AW-1:0]),
    .rd_data_o(rd_data)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q  <= HUNT;
      len_q    <= '0;
      sum_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    sum_d    = sum_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (rxDataValid && (rxByte == SYNC_BYTE)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (rxDataValid) begin
          len_d    = rxByte;
          sum_d    = rxByte;
          wr_idx_d = '0;
          if (rxByte == 8'd0) begin
            state_d = CHK;
          end else if ({1'b0, rxByte} > MAX_LEN_9) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (rxDataValid) begin
          wr_en    = 1'b1;
          sum_d    = sum_q + rxByte;
          wr_idx_d = wr_idx_q + IDX_ONE;
          if (wr_last) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (rxDataValid) begin
          if (rxByte == sum_q) begin
            ok_d     = 1'b1;
            rd_idx_d = '0;
            state_d  = (len_q != 8'd0) ? DRAIN : HUNT;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end

      DRAIN: begin
        // The input cannot be stalled, so anything arriving now is lost.
        if (rxDataValid) begin
          ovr_d = 1'b1;
        end
        if (outReady) begin
          if (rd_last) begin
            rd_idx_d = '0;
            state_d  = HUNT;
          end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // Only reachable with no strobe this cycle, so no byte is lost here.
    if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    outValid = (state_q == DRAIN);
    outByte  = outValid ? rd_data : 8'h00;
    outLast  = outValid && rd_last;
    dbgState = state_q;
  end

  assign frameOk   = ok_q;
  assign frameErr  = err_q;
  assign rxOverrun = ovr_q;

endmodule
